// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift register turn a raster
// pixel stream into one registered window per valid position. Define CONV_WINDOW_STRIDE2_EN for stride-2 output.
module conv_window_3x3 #(
    parameter int IMG_W  = 227,
    parameter int IMG_H  = 227,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_W-1:0]     pixel_in,
    input  logic                  pixel_valid,
    input  logic                  frame_start,
    output logic [9*DATA_W-1:0]   win_out,
    output logic                  win_valid,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Stream handshake: pixel_valid alone accepts pixel_in; there is no ready, so every
    // valid cycle advances the counters, line buffers and shift register by one pixel.

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [RW-1:0]     row_q, row_d, cur_row;

    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    logic [DATA_W-1:0] sr_q [9];
    logic [DATA_W-1:0] sr_d [9];

    logic [9*DATA_W-1:0] win_q, win_d;
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;

    logic                pos_ok;
    logic                stride_ok;
    logic                win_hit;

    // frame_start overrides the counters so the accepted pixel is always (0,0).
    always_comb begin
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        lb0_rd  = lb0_mem[cur_col];
        lb1_rd  = lb1_mem[cur_col];
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pixel_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    // Element index k = 3*i + j; column 2 of each row takes the newest sample.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            sr_d[k] = sr_q[k];
        end
        if (pixel_valid) begin
            for (int i = 0; i < 3; i++) begin
                sr_d[3*i]     = sr_q[3*i + 1];
                sr_d[3*i + 1] = sr_q[3*i + 2];
            end
            sr_d[2] = lb1_rd;
            sr_d[5] = lb0_rd;
            sr_d[8] = pixel_in;
        end
    end

    always_comb begin
        pos_ok = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
`ifdef CONV_WINDOW_STRIDE2_EN
        // Top-left (row-2, col-2) even is the same as row and col both even.
        stride_ok = !cur_row[0] && !cur_col[0];
`else
        stride_ok = 1'b1;
`endif
        win_hit = pixel_valid && pos_ok && stride_ok;
    end

    always_comb begin
        win_d = win_q;
        if (win_hit) begin
            for (int k = 0; k < 9; k++) begin
                win_d[DATA_W*k +: DATA_W] = sr_d[k];
            end
        end
        win_valid_d  = win_hit;
        frame_done_d = pixel_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                sr_q[k] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 9; k++) begin
                sr_q[k] <= sr_d[k];
            end
        end
    end

    // Line buffers are never cleared; stale rows are hidden by the row >= 2 gating.
    always_ff @(posedge clk) begin
        if (rstn && pixel_valid) begin
            lb1_mem[cur_col] <= lb0_rd;
            lb0_mem[cur_col] <= pixel_in;
        end
    end

    assign win_out    = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3 on a 5x4 image with ramp pixels base + 5*row + col.
module tb_conv_window_3x3;

    localparam int W = 5;
    localparam int H = 4;
    localparam int D = 8;
`ifdef CONV_WINDOW_STRIDE2_EN
    localparam int EXP_WINS = 2;
`else
    localparam int EXP_WINS = 6;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic [D-1:0]     pixel_in;
    logic             pixel_valid;
    logic             frame_start;
    logic [9*D-1:0]   win_out;
    logic             win_valid;
    logic             frame_done;

    int total = 0;
    int bad   = 0;
    int win_cnt;
    logic [9*D-1:0] last_win;
    logic [9*D-1:0] first_seen;
    logic [9*D-1:0] last_seen;

    conv_window_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(D)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .win_out     (win_out),
        .win_valid   (win_valid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9*D-1:0] obs, input logic [9*D-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*D-1:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        logic [9*D-1:0] w;
        w = {D'(e8), D'(e7), D'(e6), D'(e5), D'(e4), D'(e3), D'(e2), D'(e1), D'(e0)};
        return w;
    endfunction

    function automatic logic [9*D-1:0] exp_window(input int base, input int r, input int c);
        logic [9*D-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[D*(3*i + j) +: D] = D'(base + W*(r - 2 + i) + (c - 2 + j));
            end
        end
        return w;
    endfunction

    task automatic step(input logic v, input logic fs, input logic [D-1:0] px);
        pixel_valid = v;
        frame_start = fs;
        pixel_in    = px;
        @(posedge clk);
        #1;
    endtask

    // Pixels first..last of a frame (indices relative to (0,0)); optional idle cycle after each.
    task automatic run_frame(input int base, input bit fs, input int first, input int last, input bit gap);
        int r;
        int c;
        bit hit;
        for (int idx = first; idx <= last; idx++) begin
            r = idx / W;
            c = idx % W;
            step(1'b1, fs && (idx == first), D'(base + idx));
            hit = (r >= 2) && (c >= 2);
`ifdef CONV_WINDOW_STRIDE2_EN
            hit = hit && (r % 2 == 0) && (c % 2 == 0);
`endif
            if (hit) last_win = exp_window(base, r, c);
            if (win_valid === 1'b1) begin
                if (win_cnt == 0) first_seen = win_out;
                last_seen = win_out;
                win_cnt++;
            end
            check("win_valid", 72'(win_valid), 72'(hit));
            check("win_out", win_out, last_win);
            check("frame_done", 72'(frame_done), 72'(idx == W*H - 1));
            if (gap) begin
                step(1'b0, 1'b0, D'($urandom_range(0, 255)));
                check("idle_win_valid", 72'(win_valid), 72'(0));
                check("idle_frame_done", 72'(frame_done), 72'(0));
                check("idle_win_out", win_out, last_win);
            end
        end
    endtask

    initial begin
        rstn        = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        pixel_in    = '0;
        last_win    = '0;
        first_seen  = '0;
        last_seen   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_win_out", win_out, '0);
        check("rst_win_valid", 72'(win_valid), 72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        rstn = 1'b1;

        // Continuous ramp frame.
        win_cnt = 0;
        run_frame(0, 1'b1, 0, W*H - 1, 1'b0);
        check("cont_count", 72'(win_cnt), 72'(EXP_WINS));
        check("cont_first", first_seen, pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
`ifdef CONV_WINDOW_STRIDE2_EN
        check("cont_last", last_seen, pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));
`else
        check("cont_last", last_seen, pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
`endif

        // Same frame with pixel_valid toggling every cycle.
        win_cnt = 0;
        run_frame(0, 1'b1, 0, W*H - 1, 1'b1);
        check("gap_count", 72'(win_cnt), 72'(EXP_WINS));
        check("gap_first", first_seen, pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));

        // Back-to-back frames; second frame offset by 100.
        win_cnt = 0;
        run_frame(0, 1'b1, 0, W*H - 1, 1'b0);
        win_cnt = 0;
        run_frame(100, 1'b1, 0, W*H - 1, 1'b0);
        check("b2b_count", 72'(win_cnt), 72'(EXP_WINS));
        check("b2b_first", first_seen, pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));

        // Reset after pixel 13, then a fresh frame without frame_start.
        win_cnt = 0;
        run_frame(0, 1'b1, 0, 13, 1'b0);
        rstn = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        check("midrst_win_out", win_out, '0);
        check("midrst_win_valid", 72'(win_valid), 72'(0));
        check("midrst_frame_done", 72'(frame_done), 72'(0));
        rstn     = 1'b1;
        last_win = '0;
        win_cnt  = 0;
        run_frame(50, 1'b0, 0, W*H - 1, 1'b0);
        check("postrst_count", 72'(win_cnt), 72'(EXP_WINS));
        check("postrst_first", first_seen, pack9(50, 51, 52, 55, 56, 57, 60, 61, 62));

        // frame_start on pixel 8: truncated frame, then the resynced frame from (0,0).
        win_cnt = 0;
        run_frame(0, 1'b1, 0, 7, 1'b0);
        check("trunc_count", 72'(win_cnt), 72'(0));
        run_frame(200, 1'b1, 0, W*H - 1, 1'b0);
        check("resync_count", 72'(win_cnt), 72'(EXP_WINS));
        check("resync_first", first_seen, pack9(200, 201, 202, 205, 206, 207, 210, 211, 212));

        step(1'b0, 1'b0, 8'h00);
        check("end_win_valid", 72'(win_valid), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
